// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader that fills the instruction memory and holds the CPU until a clean load.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte (CHK state).
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_FIN    = 3'd5
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHK;
`else
  localparam state_t S_TAIL = S_FIN;
`endif

  state_t state, next_state;

  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  word_idx_q, word_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       word_buf_q, word_buf_d;
  logic              ovf_q, ovf_d;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [31:0]       wr_data_d;
  logic              cpu_hold_d, busy_d, done_d, err_d, in_ready_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
  logic              chk_err_q, chk_err_d;
`endif

  logic accept;
  logic last_byte;
  logic in_range;
  logic load_err;

  assign accept    = in_valid && in_ready;
  assign last_byte = (byte_cnt_q == 2'd3) && (word_idx_q == len_q - CNT_W'(1));
  assign in_range  = 32'(word_idx_q) < DEPTH;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign load_err  = ovf_q || chk_err_q;
`else
  assign load_err  = ovf_q;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start)  next_state = S_LEN_LO;
      S_LEN_LO: if (accept) next_state = S_LEN_HI;
      S_LEN_HI: if (accept) next_state = ({in_data, len_q[7:0]} == 16'd0) ? S_TAIL : S_DATA;
      S_DATA:   if (accept && last_byte) next_state = S_TAIL;
      S_CHK:    if (accept) next_state = S_FIN;
      S_FIN:    next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Output / datapath next values; every output is registered from these
  always_comb begin
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    word_buf_d = word_buf_q;
    ovf_d      = ovf_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    cpu_hold_d = cpu_hold;
    done_d     = done;
    err_d      = err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d      = chk_q;
    chk_err_d  = chk_err_q;
`endif
    busy_d     = (next_state != S_IDLE);
    in_ready_d = (next_state == S_LEN_LO) || (next_state == S_LEN_HI) ||
                 (next_state == S_DATA)   || (next_state == S_CHK);

    case (state)
      S_IDLE: begin
        if (start) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          ovf_d      = 1'b0;
          word_idx_d = '0;
          byte_cnt_d = '0;
          cpu_hold_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d      = '0;
          chk_err_d  = 1'b0;
`endif
        end
      end
      S_LEN_LO: if (accept) len_d[7:0]  = in_data;
      S_LEN_HI: if (accept) len_d[15:8] = in_data;
      S_DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d = chk_q ^ in_data;
`endif
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: word_buf_d[7:0]   = in_data;
            2'd1: word_buf_d[15:8]  = in_data;
            2'd2: word_buf_d[23:16] = in_data;
            default: begin
              // Words past the memory depth are consumed but never written
              if (in_range) begin
                wr_en_d   = 1'b1;
                wr_addr_d = ADDR_W'(word_idx_q);
                wr_data_d = {in_data, word_buf_q};
              end else begin
                ovf_d = 1'b1;
              end
              word_idx_d = word_idx_q + CNT_W'(1);
            end
          endcase
        end
      end
      S_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept && (in_data != chk_q)) chk_err_d = 1'b1;
`endif
      end
      S_FIN: begin
        if (load_err) begin
          err_d = 1'b1;
        end else begin
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      word_buf_q <= '0;
      ovf_q      <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      in_ready   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q      <= '0;
      chk_err_q  <= 1'b0;
`endif
    end else begin
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_buf_q <= word_buf_d;
      ovf_q      <= ovf_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      cpu_hold   <= cpu_hold_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      in_ready   <= in_ready_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
      chk_err_q  <= chk_err_d;
`endif
    end
  end

endmodule
